// File: rtl/space_pkg.sv
// Shared types and screen geometry for the space game datapath.
package space_pkg;

    // Bullet controller FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_MAX    = SCREEN_W - 1;

    // Coordinate widths, shared with the collision detector.
    localparam int X_W = 10;
    localparam int Y_W = 9;

endpackage

// File: rtl/bullet_controller_if.sv
// Bullet controller signal bundle.
// Handshake: none of these signals use valid/ready; frame_tick is a
// one-cycle strobe, fire is a level, and hit_pulse/miss_pulse are
// one-cycle strobes that the consumer must sample on the cycle they are high.
interface bullet_controller_if;
    import space_pkg::*;

    logic             frame_tick;
    logic             fire;
    logic [X_W-1:0]   player_x;
    logic             collision;
    logic [X_W-1:0]   bullet_x;
    logic [Y_W-1:0]   bullet_y;
    logic             bullet_active;
    logic             hit_pulse;
    logic             miss_pulse;
    logic [7:0]       shots_fired;
    state_t           state;        // debug view of the controller FSM

    // Game logic side: drives inputs, observes bullet.
    modport master (
        output frame_tick, fire, player_x, collision,
        input  bullet_x, bullet_y, bullet_active, hit_pulse, miss_pulse,
               shots_fired, state
    );

    // Controller side.
    modport slave (
        input  frame_tick, fire, player_x, collision,
        output bullet_x, bullet_y, bullet_active, hit_pulse, miss_pulse,
               shots_fired, state
    );

endinterface

// File: rtl/bullet_controller_edge_detect.sv
// Rising-edge detector for a button level that is already synchronous.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    // Remember last cycle's level so a held button yields one edge only.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/bullet_controller.sv
// Player bullet driver: launch on fire edge, climb per frame, retire on hit
// or at the top of the screen, then wait out a cooldown before re-arming.
module bullet_controller
    import space_pkg::*;
#(
    parameter int SPEED           = 4,
    parameter int START_Y         = 440,
    parameter int X_OFFSET        = 10,
    parameter int X_MAX           = space_pkg::X_MAX,
    parameter int COOLDOWN_FRAMES = 8
) (
    input logic                clk,
    input logic                reset,
    bullet_controller_if.slave bus
);

    state_t          state, state_n;
    logic [X_W-1:0]  x_r, x_n;
    logic [Y_W-1:0]  y_r, y_n;
    logic            active_r, active_n;
    logic            hit_r, hit_n;
    logic            miss_r, miss_n;
    logic [7:0]      shots_r, shots_n;
    logic [7:0]      cool_r, cool_n;
    logic            launch_req;
    logic [X_W:0]    x_sum;
    logic            hit_now;

    edge_detect u_fire_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.fire),
        .rise  (launch_req)
    );

    // One extra bit so a ship near the right edge saturates instead of wrapping.
    assign x_sum   = {1'b0, bus.player_x} + (X_W+1)'(X_OFFSET);
    // The collision detector is only meaningful while a bullet is on screen.
    assign hit_now = bus.collision & active_r;

    // State and bullet registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            x_r      <= '0;
            y_r      <= '0;
            active_r <= 1'b0;
            hit_r    <= 1'b0;
            miss_r   <= 1'b0;
            shots_r  <= '0;
            cool_r   <= '0;
        end else begin
            state    <= state_n;
            x_r      <= x_n;
            y_r      <= y_n;
            active_r <= active_n;
            hit_r    <= hit_n;
            miss_r   <= miss_n;
            shots_r  <= shots_n;
            cool_r   <= cool_n;
        end
    end

    // Next-state and next-bullet logic; pulses default low every cycle.
    always_comb begin
        state_n  = state;
        x_n      = x_r;
        y_n      = y_r;
        active_n = active_r;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        shots_n  = shots_r;
        cool_n   = cool_r;
        case (state)
            IDLE: begin
                if (launch_req) begin
                    x_n      = (x_sum > (X_W+1)'(X_MAX)) ? X_W'(X_MAX) : x_sum[X_W-1:0];
                    y_n      = Y_W'(START_Y);
                    active_n = 1'b1;
                    shots_n  = shots_r + 8'd1;
                    state_n  = FLIGHT;
                end
            end
            FLIGHT: begin
                if (hit_now) begin
                    // A hit wins over a same-cycle frame step; position is frozen.
                    active_n = 1'b0;
                    hit_n    = 1'b1;
                    cool_n   = 8'(COOLDOWN_FRAMES);
                    state_n  = COOLDOWN;
                end else if (bus.frame_tick && (y_r < Y_W'(SPEED))) begin
                    // Retire rather than step below row 0.
                    active_n = 1'b0;
                    miss_n   = 1'b1;
                    cool_n   = 8'(COOLDOWN_FRAMES);
                    state_n  = COOLDOWN;
                end else if (bus.frame_tick) begin
                    y_n = y_r - Y_W'(SPEED);
                end
            end
            COOLDOWN: begin
                if (bus.frame_tick) begin
                    if (cool_r == 8'd0) begin
                        state_n = IDLE;
                    end else begin
                        cool_n = cool_r - 8'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.bullet_x      = x_r;
    assign bus.bullet_y      = y_r;
    assign bus.bullet_active = active_r;
    assign bus.hit_pulse     = hit_r;
    assign bus.miss_pulse    = miss_r;
    assign bus.shots_fired   = shots_r;
    assign bus.state         = state;

endmodule
